// File: rtl/pipe_buf_stage.sv
// -----------------------------------------------------------------------------
// pipe_buf_stage
//
// Generic pipeline buffer stage with a valid/ready handshake, used between
// processor stages in place of fixed stage registers. The payload is any packed
// stage struct, passed flat as DATA_W bits.
//
// SKID=1 gives a 2-entry skid buffer. in_ready is registered, so there is no
// combinational path from out_ready to in_ready.
// SKID=0 gives a single register. in_ready is combinational:
// !main_valid | out_ready.
//
// Flush and reset both empty the stage and load NOP_PAYLOAD, the bubble, into
// the head slot.
//
// Optional build macro PIPE_BUF_STAGE_STATS_EN adds two saturating counters:
//   stall_cnt  cycles with out_valid & !out_ready
//   flush_cnt  edges where flush_i=1 while the stage held entries
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   synchronous active-low reset
//   flush_i    in   synchronous kill of all held entries
//   in_valid   in   upstream entry valid
//   in_ready   out  stage can accept this cycle
//   in_data    in   [DATA_W] upstream payload
//   out_valid  out  out_data holds a live entry
//   out_ready  in   downstream accepts this cycle
//   out_data   out  [DATA_W] head payload
//   occupancy  out  [2] live entries held (0..2)
//   stall_cnt  out  [32] (PIPE_BUF_STAGE_STATS_EN only)
//   flush_cnt  out  [16] (PIPE_BUF_STAGE_STATS_EN only)
// -----------------------------------------------------------------------------
module pipe_buf_stage #(
    parameter int                DATA_W      = 32,
    parameter int                SKID        = 1,
    parameter logic [DATA_W-1:0] NOP_PAYLOAD = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef PIPE_BUF_STAGE_STATS_EN
    output logic [31:0]       stall_cnt,
    output logic [15:0]       flush_cnt,
`endif
    output logic [1:0]        occupancy
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              in_ready_q,   in_ready_d;
    logic [1:0]        occupancy_q,  occupancy_d;

    logic accept;
    logic take;

    // With SKID=0 the skid slot never fills, so its registers stay constant
    // and synthesis trims them away.
    assign in_ready  = (SKID != 0) ? in_ready_q : (!main_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign take      = main_valid_q && out_ready;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign occupancy = occupancy_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (flush_i) begin
            // A take in this cycle still completes downstream.
            // A same-cycle accept is dropped.
            main_valid_d = 1'b0;
            main_data_d  = NOP_PAYLOAD;
            skid_valid_d = 1'b0;
        end else if (SKID != 0) begin
            if (!main_valid_q || take) begin
                // The head slot frees up. The skid entry is older than the
                // incoming word, so it moves into the head first to keep the
                // stage FIFO-ordered.
                if (skid_valid_q) begin
                    main_valid_d = 1'b1;
                    main_data_d  = skid_data_q;
                    if (accept) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = in_data;
                    end else begin
                        skid_valid_d = 1'b0;
                    end
                end else if (accept) begin
                    main_valid_d = 1'b1;
                    main_data_d  = in_data;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (accept) begin
                // The head is stalled, so the new word parks in the skid slot.
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end else begin
            if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end else if (take) begin
                main_valid_d = 1'b0;
            end
        end

        // The registered ready looks ahead at the next skid state.
        // A free skid slot guarantees room for one more word next cycle.
        in_ready_d  = !skid_valid_d;
        occupancy_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= NOP_PAYLOAD;
            skid_valid_q <= 1'b0;
            skid_data_q  <= NOP_PAYLOAD;
            in_ready_q   <= 1'b1;
            occupancy_q  <= 2'd0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            occupancy_q  <= occupancy_d;
        end
    end

`ifdef PIPE_BUF_STAGE_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (main_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_i && (occupancy_q != 2'd0) && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // Flush does not clear these counters; only reset does.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_buf_stage.sv
module tb_pipe_buf_stage;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       flush_i = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;

    logic       s_in_ready, s_out_valid;
    logic [7:0] s_out_data;
    logic [1:0] s_occ;
    logic       n_in_ready, n_out_valid;
    logic [7:0] n_out_data;
    logic [1:0] n_occ;
`ifdef PIPE_BUF_STAGE_STATS_EN
    logic [31:0] s_stall, n_stall;
    logic [15:0] s_flush, n_flush;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_buf_stage #(.DATA_W(8), .SKID(1), .NOP_PAYLOAD(8'h00)) u_skid (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
`ifdef PIPE_BUF_STAGE_STATS_EN
        .stall_cnt(s_stall), .flush_cnt(s_flush),
`endif
        .occupancy(s_occ)
    );

    pipe_buf_stage #(.DATA_W(8), .SKID(0), .NOP_PAYLOAD(8'h00)) u_noskid (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
`ifdef PIPE_BUF_STAGE_STATS_EN
        .stall_cnt(n_stall), .flush_cnt(n_flush),
`endif
        .occupancy(n_occ)
    );

    typedef struct packed {
        logic       rst_n;
        logic       flush;
        logic       iv;
        logic [7:0] din;
        logic       ordy;
        logic       exp_ov;
        logic [7:0] exp_od;
        logic [1:0] exp_occ;
        logic       exp_ir;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(logic r, logic f, logic iv, logic [7:0] d, logic o,
                                logic eov, logic [7:0] eod, logic [1:0] eocc, logic eir);
        vec_t v;
        v.rst_n = r; v.flush = f; v.iv = iv; v.din = d; v.ordy = o;
        v.exp_ov = eov; v.exp_od = eod; v.exp_occ = eocc; v.exp_ir = eir;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic f, input logic iv, input logic [7:0] d, input logic o);
        reset_n = r; flush_i = f; in_valid = iv; in_data = d; out_ready = o;
    endtask

    initial begin
        // Expected state after the edge of each row (SKID=1 instance).
        //              rst flush iv  din    ordy  ov  od     occ  ir
        vecs[0]  = mk(0, 0, 0, 8'h00, 0,   0, 8'h00, 2'd0, 1); // reset
        vecs[1]  = mk(1, 0, 1, 8'h11, 1,   1, 8'h11, 2'd1, 1); // streaming
        vecs[2]  = mk(1, 0, 1, 8'h12, 1,   1, 8'h12, 2'd1, 1);
        vecs[3]  = mk(1, 0, 1, 8'h13, 1,   1, 8'h13, 2'd1, 1);
        vecs[4]  = mk(1, 0, 0, 8'h00, 1,   0, 8'h13, 2'd0, 1); // drained
        vecs[5]  = mk(1, 0, 1, 8'hA1, 0,   1, 8'hA1, 2'd1, 1); // fill
        vecs[6]  = mk(1, 0, 1, 8'hA2, 0,   1, 8'hA1, 2'd2, 0);
        vecs[7]  = mk(1, 0, 1, 8'hA3, 0,   1, 8'hA1, 2'd2, 0); // A3 held upstream
        vecs[8]  = mk(1, 0, 1, 8'hA3, 1,   1, 8'hA2, 2'd1, 1); // skid->main, no accept
        vecs[9]  = mk(1, 0, 1, 8'hA3, 1,   1, 8'hA3, 2'd1, 1);
        vecs[10] = mk(1, 0, 0, 8'h00, 1,   0, 8'hA3, 2'd0, 1);
        vecs[11] = mk(1, 0, 1, 8'hB1, 0,   1, 8'hB1, 2'd1, 1);
        vecs[12] = mk(1, 0, 1, 8'hB2, 0,   1, 8'hB1, 2'd2, 0);
        vecs[13] = mk(1, 1, 1, 8'hB3, 0,   0, 8'h00, 2'd0, 1); // flush when full
        vecs[14] = mk(1, 0, 0, 8'h00, 1,   0, 8'h00, 2'd0, 1); // B3 never shows
        vecs[15] = mk(1, 0, 1, 8'hD1, 0,   1, 8'hD1, 2'd1, 1);
        vecs[16] = mk(1, 0, 1, 8'hD2, 0,   1, 8'hD1, 2'd2, 0);
        vecs[17] = mk(0, 0, 1, 8'hD3, 0,   0, 8'h00, 2'd0, 1); // mid-stream reset
        vecs[18] = mk(1, 0, 0, 8'h00, 1,   0, 8'h00, 2'd0, 1);
        vecs[19] = mk(1, 0, 1, 8'hE1, 0,   1, 8'hE1, 2'd1, 1);
        vecs[20] = mk(1, 0, 1, 8'hE2, 1,   1, 8'hE2, 2'd1, 1); // take+accept at occ=1
        vecs[21] = mk(1, 0, 0, 8'h00, 0,   1, 8'hE2, 2'd1, 1); // held stable
        vecs[22] = mk(1, 0, 0, 8'h00, 1,   0, 8'hE2, 2'd0, 1);

        #1;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst_n, vecs[i].flush, vecs[i].iv, vecs[i].din, vecs[i].ordy);
            step();
            check($sformatf("v%0d.out_valid", i), 32'(s_out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("v%0d.out_data",  i), 32'(s_out_data),  32'(vecs[i].exp_od));
            check($sformatf("v%0d.occupancy", i), 32'(s_occ),       32'(vecs[i].exp_occ));
            check($sformatf("v%0d.in_ready",  i), 32'(s_in_ready),  32'(vecs[i].exp_ir));
            $display("vec %0d: in_v=%0b in_d=%h ordy=%0b -> out_v=%0b out_d=%h occ=%0d in_rdy=%0b",
                     i, vecs[i].iv, vecs[i].din, vecs[i].ordy, s_out_valid, s_out_data, s_occ, s_in_ready);
        end

        // SKID=0 sequence: the combinational in_ready and the single register.
        drive(0, 0, 0, 8'h00, 0);
        step();
        check("ns.reset_occ", 32'(n_occ), 32'd0);
        check("ns.reset_ir", 32'(n_in_ready), 32'd1);
        drive(1, 0, 1, 8'hC4, 0);
        step();
        check("ns.c4_data", 32'(n_out_data), 32'hC4);
        check("ns.c4_occ", 32'(n_occ), 32'd1);
        drive(1, 0, 1, 8'hC6, 0);
        #1;
        check("ns.full_ir", 32'(n_in_ready), 32'd0);
        step();
        check("ns.held_data", 32'(n_out_data), 32'hC4);
        drive(1, 0, 1, 8'hC5, 1);
        #1;
        check("ns.comb_ir", 32'(n_in_ready), 32'd1);
        step();
        check("ns.c5_data", 32'(n_out_data), 32'hC5);
        check("ns.c5_valid", 32'(n_out_valid), 32'd1);
        check("ns.c5_occ", 32'(n_occ), 32'd1);
        $display("noskid: replaced payload -> out_d=%h occ=%0d", n_out_data, n_occ);
        drive(1, 0, 0, 8'h00, 1);
        step();
        check("ns.drain_valid", 32'(n_out_valid), 32'd0);
        check("ns.drain_occ", 32'(n_occ), 32'd0);

`ifdef PIPE_BUF_STAGE_STATS_EN
        drive(0, 0, 0, 8'h00, 0);
        step();
        check("st.reset_stall", s_stall, 32'd0);
        drive(1, 0, 1, 8'hF1, 1);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 8'h00, 0);
            step();
        end
        drive(1, 1, 0, 8'h00, 1);
        step();
        drive(1, 0, 0, 8'h00, 1);
        check("st.stall_cnt", s_stall, 32'd5);
        check("st.flush_cnt", 32'(s_flush), 32'd1);
        check("st.noskid_stall", n_stall, 32'd5);
        $display("stats: stall_cnt=%0d flush_cnt=%0d", s_stall, s_flush);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
